// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: word width, feedback taps, next-word function and
// checker state encoding. Imported by both the generator and the checker so
// the two ends of the link always agree on the sequence.
package prbs_pkg;

  localparam int PRBS_LENGTH = 32;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1 (bit indices of the word)
  localparam int PRBS_TAP_A = 31;
  localparam int PRBS_TAP_B = 21;
  localparam int PRBS_TAP_C = 1;
  localparam int PRBS_TAP_D = 0;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_chk_state_t;

  // One LFSR shift per word: shift left, feed the tap XOR into bit 0
  function automatic logic [PRBS_LENGTH-1:0] prbs_next(input logic [PRBS_LENGTH-1:0] w);
    return {w[PRBS_LENGTH-2:0], w[PRBS_TAP_A] ^ w[PRBS_TAP_B] ^ w[PRBS_TAP_C] ^ w[PRBS_TAP_D]};
  endfunction

endpackage

// File: rtl/prbs_popcount32.sv
// Combinational population count of a 32-bit word (result 0..32).
module prbs_popcount32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  // Sum of all set bits
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 32; i++) begin
      o_count = o_count + 6'(i_data[i]);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS-32 receive checker. Seeds a local LFSR from the incoming stream,
// confirms LOCK_COUNT consecutive matches, then free-runs and counts word and
// bit errors with saturating counters. Bit-error counting (popcount path) is
// built only when PRBS_CHK_BITERR_EN is defined; otherwise o_bit_err_cnt is 0.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8
) (
  input  logic        i_aclk,
  input  logic        i_aresetn,
  input  logic        i_enable,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_clear_cnt,
  output logic        o_locked,
  output logic        o_error,
  output logic [1:0]  o_state,
  output logic [31:0] o_word_err_cnt,
  output logic [31:0] o_bit_err_cnt
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

  prbs_chk_state_t state_q, state_d;
  logic [31:0]     exp_q, exp_d;
  logic [7:0]      match_q, match_d;
  logic [7:0]      miss_q, miss_d;
  logic            err_q, err_d;
  logic [31:0]     word_cnt_q;
  logic            hit;

  function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
    return (cnt == '1) ? cnt : cnt + 32'd1;
  endfunction

  assign hit = (i_data == exp_q);

  // Next-state logic for lock tracking and the local LFSR
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    if (!i_enable) begin
      state_d = ST_HUNT;
    end else if (i_valid) begin
      case (state_q)
        ST_HUNT: begin
          // The all-zero word is the lockup state and can never seed
          if (i_data != '0) begin
            exp_d   = prbs_next(i_data);
            match_d = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (hit) begin
            exp_d   = prbs_next(i_data);
            match_d = match_q + 8'd1;
            if (match_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else if (i_data == '0) begin
            state_d = ST_HUNT;
          end else begin
            exp_d   = prbs_next(i_data);
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Free-run so a corrupted word does not also corrupt the prediction
          exp_d = prbs_next(exp_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 8'd1;
            if (miss_q == LOSS_LAST) state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State, LFSR and run-length registers
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= ST_HUNT;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  // Saturating word-error counter; clear takes priority over an increment
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      word_cnt_q <= '0;
    end else if (i_clear_cnt) begin
      word_cnt_q <= '0;
    end else if (err_d) begin
      word_cnt_q <= sat_inc32(word_cnt_q);
    end
  end

`ifdef PRBS_CHK_BITERR_EN
  logic [5:0]  bit_pop;
  logic [31:0] bit_cnt_q;

  function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [5:0] add);
    logic [32:0] sum;
    sum = {1'b0, cnt} + 33'(add);
    return sum[32] ? '1 : sum[31:0];
  endfunction

  prbs_popcount32 u_popcount (
    .i_data  (i_data ^ exp_q),
    .o_count (bit_pop)
  );

  // Saturating bit-error counter; clear takes priority over an increment
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      bit_cnt_q <= '0;
    end else if (i_clear_cnt) begin
      bit_cnt_q <= '0;
    end else if (err_d) begin
      bit_cnt_q <= sat_add32(bit_cnt_q, bit_pop);
    end
  end

  assign o_bit_err_cnt = bit_cnt_q;
`else
  assign o_bit_err_cnt = '0;
`endif

  assign o_locked       = (state_q == ST_LOCKED);
  assign o_state        = state_q;
  assign o_error        = err_q;
  assign o_word_err_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker (LOCK_COUNT=4, LOSS_COUNT=8).
module tb_prbs_checker;

  logic        i_aclk = 1'b0;
  logic        i_aresetn;
  logic        i_enable;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_clear_cnt;
  logic        o_locked;
  logic        o_error;
  logic [1:0]  o_state;
  logic [31:0] o_word_err_cnt;
  logic [31:0] o_bit_err_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] w;
  logic [31:0] exp_bits;
  int          err_seen;

`ifdef PRBS_CHK_BITERR_EN
  localparam bit BITERR = 1'b1;
`else
  localparam bit BITERR = 1'b0;
`endif

  prbs_checker #(.LOCK_COUNT(4), .LOSS_COUNT(8)) dut (
    .i_aclk         (i_aclk),
    .i_aresetn      (i_aresetn),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_clear_cnt    (i_clear_cnt),
    .o_locked       (o_locked),
    .o_error        (o_error),
    .o_state        (o_state),
    .o_word_err_cnt (o_word_err_cnt),
    .o_bit_err_cnt  (o_bit_err_cnt)
  );

  always #5 i_aclk = ~i_aclk;

  function automatic logic [31:0] nxt(input logic [31:0] v);
    logic fb;
    fb = v[31] ^ v[21] ^ v[1] ^ v[0];
    return (v << 1) | {31'd0, fb};
  endfunction

  function automatic logic [31:0] bits_exp();
    return BITERR ? exp_bits : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge
  task automatic drive(input logic [31:0] d, input logic v, input logic clr, input logic en);
    @(negedge i_aclk);
    i_data = d; i_valid = v; i_clear_cnt = clr; i_enable = en;
    @(posedge i_aclk);
    #1;
  endtask

  task automatic good();
    drive(w, 1'b1, 1'b0, 1'b1);
    w = nxt(w);
  endtask

  task automatic acquire(input string tag);
    good();
    check({tag, "_state_seed"}, 32'(o_state), 32'd1);
    for (int i = 0; i < 3; i++) good();
    check({tag, "_unlocked_b4"}, 32'(o_locked), 32'd0);
    good();
    check({tag, "_locked_b5"}, 32'(o_locked), 32'd1);
    check({tag, "_state_b5"}, 32'(o_state), 32'd2);
  endtask

  initial begin
    i_aresetn = 1'b0; i_enable = 1'b1; i_valid = 1'b0;
    i_data = '0; i_clear_cnt = 1'b0;
    w = 32'h0000ACE1; exp_bits = '0;

    // Reset state
    repeat (2) @(posedge i_aclk);
    #1;
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_wcnt", o_word_err_cnt, 32'd0);
    check("rst_bcnt", o_bit_err_cnt, 32'd0);
    @(negedge i_aclk);
    i_aresetn = 1'b1;

    // Sequence model sanity against hand-computed words
    check("model_w2", nxt(32'h0000ACE1), 32'h000159C3);
    check("model_w3", nxt(32'h000159C3), 32'h0002B386);

    // Lock acquisition then 100 clean beats
    acquire("acq");
    err_seen = 0;
    for (int i = 0; i < 100; i++) begin
      good();
      if (o_error) err_seen++;
    end
    check("clean_errpulses", 32'(err_seen), 32'd0);
    check("clean_wcnt", o_word_err_cnt, 32'd0);
    check("clean_bcnt", o_bit_err_cnt, 32'd0);
    check("clean_locked", 32'(o_locked), 32'd1);

    // Idle cycle with garbage data must not advance anything
    drive(32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    check("idle_error", 32'(o_error), 32'd0);
    check("idle_state", 32'(o_state), 32'd2);

    // Single-bit error
    drive(w ^ 32'h1, 1'b1, 1'b0, 1'b1);
    w = nxt(w);
    exp_bits = 32'd1;
    check("sbe_error", 32'(o_error), 32'd1);
    check("sbe_wcnt", o_word_err_cnt, 32'd1);
    check("sbe_bcnt", o_bit_err_cnt, bits_exp());
    check("sbe_locked", 32'(o_locked), 32'd1);
    good();
    check("sbe_after_error", 32'(o_error), 32'd0);
    good();
    check("sbe_after_wcnt", o_word_err_cnt, 32'd1);

    // Multi-bit error
    drive(w ^ 32'h80000006, 1'b1, 1'b0, 1'b1);
    w = nxt(w);
    exp_bits = 32'd4;
    check("mbe_error", 32'(o_error), 32'd1);
    check("mbe_wcnt", o_word_err_cnt, 32'd2);
    check("mbe_bcnt", o_bit_err_cnt, bits_exp());
    good();

    // Clear coinciding with an error beat
    drive(w ^ 32'h00000100, 1'b1, 1'b1, 1'b1);
    w = nxt(w);
    exp_bits = '0;
    check("clr_error", 32'(o_error), 32'd1);
    check("clr_wcnt", o_word_err_cnt, 32'd0);
    check("clr_bcnt", o_bit_err_cnt, bits_exp());
    good();
    check("clr_locked", 32'(o_locked), 32'd1);

    // Lock loss: eight all-ones words
    for (int i = 0; i < 8; i++) begin
      drive(32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
      exp_bits = exp_bits + 32'(32 - $countones(w));
      w = nxt(w);
      if (i == 6) begin
        check("loss_locked_b7", 32'(o_locked), 32'd1);
        check("loss_wcnt_b7", o_word_err_cnt, 32'd7);
      end
    end
    check("loss_locked", 32'(o_locked), 32'd0);
    check("loss_state", 32'(o_state), 32'd0);
    check("loss_wcnt", o_word_err_cnt, 32'd8);
    check("loss_bcnt", o_bit_err_cnt, bits_exp());
    drive(32'h0, 1'b1, 1'b0, 1'b1);
    check("hunt_zero_state", 32'(o_state), 32'd0);

    // Re-acquire, then drop enable: back to HUNT with counters held
    acquire("reacq");
    drive(w, 1'b1, 1'b0, 1'b0);
    check("en_state", 32'(o_state), 32'd0);
    check("en_error", 32'(o_error), 32'd0);
    check("en_wcnt", o_word_err_cnt, 32'd8);
    check("en_bcnt", o_bit_err_cnt, bits_exp());

    // Reset mid-lock with an error pulse and nonzero counts
    acquire("prerst");
    drive(w ^ 32'h00010000, 1'b1, 1'b0, 1'b1);
    w = nxt(w);
    check("prerst_error", 32'(o_error), 32'd1);
    check("prerst_wcnt", o_word_err_cnt, 32'd9);
    #2;
    i_aresetn = 1'b0;
    #1;
    check("arst_state", 32'(o_state), 32'd0);
    check("arst_locked", 32'(o_locked), 32'd0);
    check("arst_error", 32'(o_error), 32'd0);
    check("arst_wcnt", o_word_err_cnt, 32'd0);
    check("arst_bcnt", o_bit_err_cnt, 32'd0);
    @(negedge i_aclk);
    i_valid = 1'b0;
    @(negedge i_aclk);
    i_aresetn = 1'b1;
    acquire("postrst");
    check("postrst_wcnt", o_word_err_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
